// File: rtl/half_duplex_xcvr.sv
// -----------------------------------------------------------------------------
// half_duplex_xcvr
//
// Half-duplex serial transceiver sharing one line through an external bidir
// buffer. One bit per clk cycle. Frame: start 0, 8 data bits LSB first,
// optional even parity, stop 1. The line is released for GUARD cycles on
// every change of direction.
//
// Optional feature: define HDX_PARITY_EN to add an even-parity bit after the
// data bits (11-bit frame); a parity mismatch on receive gives rx_err.
// Without it the frame is 10 bits and only a bad stop bit gives rx_err.
//
// Parameters:
//   GUARD     bus turnaround length in clk cycles (1..15)
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   tx_valid  byte offered for transmit
//   tx_data   byte to transmit
//   tx_ready  one-cycle accept pulse
//   rx_data   last good received byte, held until the next good frame
//   rx_valid  one-cycle pulse, good frame received
//   rx_err    one-cycle pulse, bad frame received
//   line_out  serial bit to the buffer drive side (idle 1)
//   line_in   serial bit from the buffer receive side
//   cfg       buffer direction: 00 released, 10 drive, 01 receive
//   busy      high whenever the FSM is not listening
// -----------------------------------------------------------------------------
module half_duplex_xcvr #(
    parameter int unsigned GUARD = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       line_out,
    input  logic       line_in,
    output logic [1:0] cfg,
    output logic       busy
);

    localparam logic [3:0] GuardLast = 4'(GUARD - 1);
`ifdef HDX_PARITY_EN
    localparam logic [3:0] FrameLast = 4'd10;
`else
    localparam logic [3:0] FrameLast = 4'd9;
`endif

    typedef enum logic [2:0] {
        StListen,
        StRx,
        StGuardTx,
        StTx,
        StGuardRx
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        tx_ready_q, tx_ready_d;
    logic        rx_valid_q, rx_valid_d;
    logic        rx_err_q, rx_err_d;
    logic        line_out_q, line_out_d;
    logic [1:0]  cfg_q, cfg_d;
    logic        busy_q, busy_d;
    logic [10:0] tx_frame;
`ifdef HDX_PARITY_EN
    logic        par_ok_q, par_ok_d;
`endif

    // Frame bits indexed by TX bit counter; bit 0 is the start bit.
`ifdef HDX_PARITY_EN
    assign tx_frame = {1'b1, ^tx_data_q, tx_data_q, 1'b0};
`else
    assign tx_frame = {1'b1, 1'b1, tx_data_q, 1'b0};
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tx_data_d  = tx_data_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        tx_ready_d = 1'b0;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
`ifdef HDX_PARITY_EN
        par_ok_d   = par_ok_q;
`endif

        unique case (state_q)
            StListen: begin
                // A start bit beats a pending transmit; tx_valid stays held.
                if (!line_in) begin
                    state_d = StRx;
                    cnt_d   = 4'd0;
                end else if (tx_valid) begin
                    tx_ready_d = 1'b1;
                    tx_data_d  = tx_data;
                    state_d    = StGuardTx;
                    cnt_d      = 4'd0;
                end
            end
            StRx: begin
                if (cnt_q < 4'd8) begin
                    rx_shift_d = {line_in, rx_shift_q[7:1]};
                    cnt_d      = cnt_q + 4'd1;
`ifdef HDX_PARITY_EN
                end else if (cnt_q == 4'd8) begin
                    par_ok_d = ~(^rx_shift_q ^ line_in);
                    cnt_d    = cnt_q + 4'd1;
`endif
                end else begin
                    // Stop bit sample: result shows up on the next cycle.
                    state_d = StListen;
                    cnt_d   = 4'd0;
`ifdef HDX_PARITY_EN
                    if (line_in && par_ok_q) begin
`else
                    if (line_in) begin
`endif
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                end
            end
            StGuardTx: begin
                if (cnt_q == GuardLast) begin
                    state_d = StTx;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StTx: begin
                if (cnt_q == FrameLast) begin
                    state_d = StGuardRx;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            StGuardRx: begin
                if (cnt_q == GuardLast) begin
                    state_d = StListen;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StGuardRx;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are registered and follow the state being entered.
        cfg_d = 2'b00;
        if (state_d == StListen || state_d == StRx) begin
            cfg_d = 2'b01;
        end else if (state_d == StTx) begin
            cfg_d = 2'b10;
        end
        line_out_d = (state_d == StTx) ? tx_frame[cnt_d] : 1'b1;
        busy_d     = (state_d != StListen);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StGuardRx;
            cnt_q      <= 4'd0;
            tx_data_q  <= 8'd0;
            rx_shift_q <= 8'd0;
            rx_data_q  <= 8'd0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            line_out_q <= 1'b1;
            cfg_q      <= 2'b00;
            busy_q     <= 1'b1;
`ifdef HDX_PARITY_EN
            par_ok_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tx_data_q  <= tx_data_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            line_out_q <= line_out_d;
            cfg_q      <= cfg_d;
            busy_q     <= busy_d;
`ifdef HDX_PARITY_EN
            par_ok_q   <= par_ok_d;
`endif
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign line_out = line_out_q;
    assign cfg      = cfg_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_half_duplex_xcvr.sv
// -----------------------------------------------------------------------------
// tb_half_duplex_xcvr
//
// Directed bench for half_duplex_xcvr with GUARD=2. Inputs change 1 ns after
// each rising edge; outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_half_duplex_xcvr;

    logic       clk;
    logic       rst_n;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;
    logic       line_out;
    logic       line_in;
    logic [1:0] cfg;
    logic       busy;

    int checks = 0;
    int errors = 0;

`ifdef HDX_PARITY_EN
    localparam int NBits = 11;
`else
    localparam int NBits = 10;
`endif

    half_duplex_xcvr #(.GUARD(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_err   (rx_err),
        .line_out (line_out),
        .line_in  (line_in),
        .cfg      (cfg),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line bits of a frame, index 0 = start bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic stop);
`ifdef HDX_PARITY_EN
        return {stop, ^d, d, 1'b0};
`else
        return {1'b0, stop, d, 1'b0};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Called on the cycle after tx_ready was seen; runs the guard, the frame
    // and the trailing guard, ending on the first LISTEN cycle.
    task automatic tx_after_accept(input logic [7:0] d);
        logic [10:0] f;
        f = frame_bits(d, 1'b1);
        tx_valid = 1'b0;
        step();
        chk("guard_tx_cfg", {6'd0, cfg}, 8'h00);
        chk("guard_tx_ready", {7'd0, tx_ready}, 8'h00);
        step();
        for (int i = 0; i < NBits; i++) begin
            chk("tx_cfg", {6'd0, cfg}, 8'h02);
            chk("tx_bit", {7'd0, line_out}, {7'd0, f[i]});
            chk("tx_no_ready", {7'd0, tx_ready}, 8'h00);
            step();
        end
        chk("guard_rx_cfg0", {6'd0, cfg}, 8'h00);
        chk("guard_rx_line", {7'd0, line_out}, 8'h01);
        step();
        chk("guard_rx_cfg1", {6'd0, cfg}, 8'h00);
        step();
        chk("listen_cfg", {6'd0, cfg}, 8'h01);
        chk("listen_busy", {7'd0, busy}, 8'h00);
    endtask

    // Drives frame bits first..NBits-1; returns on the cycle after the stop sample.
    task automatic rx_bits(input logic [7:0] d, input logic stop, input int first);
        logic [10:0] f;
        f = frame_bits(d, stop);
        for (int i = first; i < NBits; i++) begin
            line_in = f[i];
            step();
            chk("rx_cfg", {6'd0, cfg}, 8'h01);
            if (i < NBits - 1) begin
                chk("rx_busy", {7'd0, busy}, 8'h01);
                chk("rx_no_pulse", {6'd0, rx_valid, rx_err}, 8'h00);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        line_in  = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;

        // Reset values
        repeat (3) step();
        chk("rst_cfg", {6'd0, cfg}, 8'h00);
        chk("rst_line", {7'd0, line_out}, 8'h01);
        chk("rst_busy", {7'd0, busy}, 8'h01);
        chk("rst_pulses", {5'd0, tx_ready, rx_valid, rx_err}, 8'h00);
        chk("rst_rx_data", rx_data, 8'h00);

        rst_n = 1'b1;
        step();
        chk("post_rst_cfg0", {6'd0, cfg}, 8'h00);
        chk("post_rst_busy0", {7'd0, busy}, 8'h01);
        step();
        chk("post_rst_cfg1", {6'd0, cfg}, 8'h01);
        chk("post_rst_busy1", {7'd0, busy}, 8'h00);
        chk("post_rst_pulses", {5'd0, tx_ready, rx_valid, rx_err}, 8'h00);

        // Transmit 0xA5: line 0,1,0,1,0,0,1,0,1,1
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        step();
        chk("tx_accept", {7'd0, tx_ready}, 8'h01);
        chk("tx_accept_cfg", {6'd0, cfg}, 8'h00);
        tx_after_accept(8'hA5);

        // Receive 0x3C, then a bad-stop frame of 0x81 back-to-back
        rx_bits(8'h3C, 1'b1, 0);
        chk("rx_valid", {7'd0, rx_valid}, 8'h01);
        chk("rx_err_low", {7'd0, rx_err}, 8'h00);
        chk("rx_data", rx_data, 8'h3C);
        rx_bits(8'h81, 1'b0, 0);
        chk("bad_stop_err", {7'd0, rx_err}, 8'h01);
        chk("bad_stop_valid", {7'd0, rx_valid}, 8'h00);
        chk("bad_stop_data", rx_data, 8'h3C);
        line_in = 1'b1;
        step();
        chk("err_one_cycle", {6'd0, rx_valid, rx_err}, 8'h00);
        chk("idle_cfg", {6'd0, cfg}, 8'h01);

        // Collision: start bit and tx_valid together, receive wins
        tx_data  = 8'h96;
        tx_valid = 1'b1;
        line_in  = 1'b0;
        step();
        chk("coll_no_ready", {7'd0, tx_ready}, 8'h00);
        chk("coll_cfg", {6'd0, cfg}, 8'h01);
        chk("coll_busy", {7'd0, busy}, 8'h01);
        rx_bits(8'h0F, 1'b1, 1);
        chk("coll_rx_valid", {7'd0, rx_valid}, 8'h01);
        chk("coll_rx_data", rx_data, 8'h0F);
        chk("coll_still_no_ready", {7'd0, tx_ready}, 8'h00);
        line_in = 1'b1;
        step();
        chk("coll_tx_accept", {7'd0, tx_ready}, 8'h01);
        chk("coll_tx_cfg", {6'd0, cfg}, 8'h00);
        tx_after_accept(8'h96);

        // Abort: reset while bit 4 (a 0) of 0xA5 is on the line
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        step();
        chk("abort_accept", {7'd0, tx_ready}, 8'h01);
        tx_valid = 1'b0;
        step();
        step();
        repeat (4) step();
        chk("abort_pre_cfg", {6'd0, cfg}, 8'h02);
        chk("abort_pre_bit", {7'd0, line_out}, 8'h00);
        rst_n = 1'b0;
        #1;
        chk("abort_cfg", {6'd0, cfg}, 8'h00);
        chk("abort_line", {7'd0, line_out}, 8'h01);
        chk("abort_busy", {7'd0, busy}, 8'h01);
        chk("abort_pulses", {5'd0, tx_ready, rx_valid, rx_err}, 8'h00);
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("abort_rel_cfg", {6'd0, cfg}, 8'h00);
        chk("abort_rel_ready0", {7'd0, tx_ready}, 8'h00);
        step();
        chk("abort_listen_cfg", {6'd0, cfg}, 8'h01);
        chk("abort_rel_ready1", {7'd0, tx_ready}, 8'h00);
        step();
        chk("abort_rel_ready2", {5'd0, tx_ready, rx_valid, rx_err}, 8'h00);
        chk("abort_idle_line", {7'd0, line_out}, 8'h01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
